// File: rtl/wb_pkg.sv
// Shared constants and state encoding for the write-back controller.
//   WORD_WIDTH     : width of ALU results and memory read data
//   REG_ADDR_WIDTH : register-file index width
//   wb_state_e     : IDLE (accepting instructions) / WAIT (load outstanding)
package wb_pkg;

  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

endpackage : wb_pkg

// File: rtl/wb_wait_timer.sv
// Load wait timer: clear/enable counter with a terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : force the count to zero (has priority over en_i)
//   en_i     : advance the count by one
//   tc_c_o   : count has reached MAX_WAIT-1 (combinational from the count register)
module wb_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_c_o = (cnt_q == CNT_W'(MAX_WAIT - 1));

  // Saturate at terminal count so the count can never wrap even if clr_i is late.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_c_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : wb_wait_timer

// File: rtl/wb_writeback_ctrl.sv
// Write-back stage controller: drives one registered register-file write per
// retiring instruction. ALU results write one cycle after accept; loads stall
// the MEM stage until read data returns, a flush squashes them, or a timeout.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_wb_en/in_load: retiring instruction and its kind
//   in_dest, in_alu_res      : destination register and ALU result
//   mem_rvalid, mem_rdata    : load data return (single-cycle pulse)
//   flush                    : squash outstanding load or presented instruction
//   stall                    : hold MEM stage while a load is outstanding
//   WB_en/WB_dest/WB_result  : registered register-file write port
//   load_err                 : one-cycle pulse on load timeout
module wb_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_wb_en,
  input  logic                      in_load,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest,
  input  logic [WORD_WIDTH-1:0]     in_alu_res,
  input  logic                      mem_rvalid,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  input  logic                      flush,
  output logic                      stall,
  output logic                      WB_en,
  output logic [REG_ADDR_WIDTH-1:0] WB_dest,
  output logic [WORD_WIDTH-1:0]     WB_result,
  output logic                      load_err
);

  wb_state_e                 state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                      wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
  logic [WORD_WIDTH-1:0]     wb_result_q, wb_result_d;
  logic                      load_err_q, load_err_d;
  logic                      accept_c;
  logic                      tmr_clr_c, tmr_en_c, tmr_tc_c;

  // stall is a pure decode of the state register.
  assign stall     = (state_q == WAIT);
  assign accept_c  = in_valid & ~stall & ~flush;
  assign WB_en     = wb_en_q;
  assign WB_dest   = wb_dest_q;
  assign WB_result = wb_result_q;
  assign load_err  = load_err_q;

  wb_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr_c),
    .en_i  (tmr_en_c),
    .tc_c_o(tmr_tc_c)
  );

  // Next-state and write-port logic.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    wb_en_d     = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_result_d = wb_result_q;
    load_err_d  = 1'b0;
    tmr_clr_c   = 1'b1;
    tmr_en_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c && in_wb_en) begin
          if (in_load) begin
            state_d = WAIT;
            dest_d  = in_dest;
          end else begin
            wb_en_d     = 1'b1;
            wb_dest_d   = in_dest;
            wb_result_d = in_alu_res;
          end
        end
      end
      WAIT: begin
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b1;
        // Flush beats data returning in the same cycle; data beats timeout.
        if (flush) begin
          state_d   = IDLE;
          tmr_clr_c = 1'b1;
        end else if (mem_rvalid) begin
          state_d     = IDLE;
          tmr_clr_c   = 1'b1;
          wb_en_d     = 1'b1;
          wb_dest_d   = dest_q;
          wb_result_d = mem_rdata;
        end else if (tmr_tc_c) begin
          state_d    = IDLE;
          tmr_clr_c  = 1'b1;
          load_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      wb_en_q     <= 1'b0;
      wb_dest_q   <= '0;
      wb_result_q <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      wb_en_q     <= wb_en_d;
      wb_dest_q   <= wb_dest_d;
      wb_result_q <= wb_result_d;
      load_err_q  <= load_err_d;
    end
  end

endmodule : wb_writeback_ctrl

// File: tb/tb_wb_writeback_ctrl.sv
// Randomised scoreboard bench for wb_writeback_ctrl. The driver works at
// transaction level (instruction, load outcome and latency) and pushes the
// write-port events it expects, tagged with the clock edge they must follow;
// an independent monitor pops and compares whenever the DUT shows an event.
module tb_wb_writeback_ctrl;

  localparam int unsigned MAXW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_wb_en = 1'b0, in_load = 1'b0;
  logic [3:0]  in_dest = '0;
  logic [31:0] in_alu_res = '0, mem_rdata = '0;
  logic        mem_rvalid = 1'b0, flush = 1'b0;
  logic        stall, WB_en, load_err;
  logic [3:0]  WB_dest;
  logic [31:0] WB_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b1;

  always #5 clk = ~clk;

  wb_writeback_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wb_en(in_wb_en),
    .in_load(in_load), .in_dest(in_dest), .in_alu_res(in_alu_res),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .stall(stall), .WB_en(WB_en), .WB_dest(WB_dest), .WB_result(WB_result),
    .load_err(load_err)
  );

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [3:0] dest;
    logic [31:0] data;
  } exp_t;

  // kind: 0 instruction, 1 idle gap, 2 squashed presentation, 3 stray rvalid
  // outcome (loads only): 0 data after lat cycles, 1 timeout, 2 flush at cycle lat
  typedef struct {
    int          kind;
    bit          wb_en;
    bit          load;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          outcome;
    int          lat;
    bit          rv_flush;
  } txn_t;

  exp_t expq[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: compares every write-port event against the scoreboard.
  initial begin : monitor
    exp_t e;
    logic [3:0]  last_dest;
    logic [31:0] last_res;
    last_dest = '0;
    last_res  = '0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb_en", 32'(WB_en), 0);
        chk("rst_load_err", 32'(load_err), 0);
        chk("rst_wb_dest", 32'(WB_dest), 0);
        chk("rst_wb_result", WB_result, 0);
        last_dest = '0;
        last_res  = '0;
      end else if (WB_en || load_err) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got WB_en=%0b load_err=%0b dest=%0d data=%h expected no event (edge %0d)",
                   WB_en, load_err, WB_dest, WB_result, cyc);
        end else begin
          e = expq.pop_front();
          chk("event_edge", 32'(cyc), 32'(e.cyc));
          chk("load_err", 32'(load_err), 32'(e.is_err));
          chk("wb_en", 32'(WB_en), 32'(!e.is_err));
          if (e.is_err) begin
            chk("err_hold_dest", 32'(WB_dest), 32'(last_dest));
            chk("err_hold_result", WB_result, last_res);
          end else begin
            chk("wb_dest", 32'(WB_dest), 32'(e.dest));
            chk("wb_result", WB_result, e.data);
            last_dest = e.dest;
            last_res  = e.data;
          end
        end
      end else begin
        chk("hold_dest", 32'(WB_dest), 32'(last_dest));
        chk("hold_result", WB_result, last_res);
        if (expq.size() != 0 && expq[0].cyc <= cyc) begin
          e = expq.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_event: got no event expected %s dest=%0d data=%h at edge %0d (now %0d)",
                   e.is_err ? "load_err" : "write", e.dest, e.data, e.cyc, cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of stimulus expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic txn_t mk(input int kind, input bit wb_en, input bit load, input logic [3:0] dest,
                              input logic [31:0] alu, input logic [31:0] rdata, input int outcome,
                              input int lat, input bit rv_flush);
    txn_t t;
    t.kind = kind; t.wb_en = wb_en; t.load = load; t.dest = dest; t.alu = alu;
    t.rdata = rdata; t.outcome = outcome; t.lat = lat; t.rv_flush = rv_flush;
    return t;
  endfunction

  function automatic txn_t gen();
    txn_t t;
    int   r, o;
    r = int'($urandom_range(0, 99));
    o = int'($urandom_range(0, 99));
    t = mk(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 4'($urandom), $urandom, $urandom,
           (o < 60) ? 0 : (o < 75) ? 1 : 2, int'($urandom_range(1, MAXW)), $urandom_range(0, 1) == 1);
    if (r >= 90)      t.kind = 3;
    else if (r >= 80) t.kind = 2;
    else if (r >= 60) t.kind = 1;
    return t;
  endfunction

  task automatic step(input bit exp_stall, input string nm);
    @(posedge clk);
    #1;
    chk(nm, 32'(stall), 32'(exp_stall));
  endtask

  task automatic present(input txn_t t);
    in_valid   = 1'b1;
    in_wb_en   = t.wb_en;
    in_load    = t.load;
    in_dest    = t.dest;
    in_alu_res = t.alu;
  endtask

  task automatic push(input bit is_err, input logic [3:0] dest, input logic [31:0] data);
    exp_t e;
    e.cyc = cyc + 1; e.is_err = is_err; e.dest = dest; e.data = data;
    expq.push_back(e);
  endtask

  // Outstanding load: upstream keeps presenting the next instruction meanwhile.
  task automatic run_wait(input txn_t t, input txn_t nx);
    int limit;
    limit = (t.outcome == 1) ? int'(MAXW) : t.lat;
    for (int i = 1; i <= limit; i++) begin
      flush      = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (nx.kind == 0) present(nx);
      else begin
        in_valid = $urandom_range(0, 1) == 1; in_wb_en = 1'b1; in_load = $urandom_range(0, 1) == 1;
        in_dest = 4'($urandom); in_alu_res = $urandom;
      end
      if (i == limit) begin
        if (t.outcome == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = t.rdata;
          push(1'b0, t.dest, t.rdata);
        end else if (t.outcome == 1) begin
          push(1'b1, '0, '0);
        end else begin
          flush      = 1'b1;
          mem_rvalid = t.rv_flush;
        end
      end
      step(i < limit, "stall_wait");
    end
    flush      = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic run(input txn_t t, input txn_t nx);
    flush      = 1'b0;
    mem_rvalid = $urandom_range(0, 1) == 1;
    mem_rdata  = $urandom;
    case (t.kind)
      1: begin
        in_valid = 1'b0;
        step(1'b0, "stall_gap");
      end
      2: begin
        present(t);
        flush = 1'b1;
        step(1'b0, "stall_squash");
      end
      3: begin
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        step(1'b0, "stall_stray_rvalid");
      end
      default: begin
        present(t);
        if (t.wb_en && t.load) begin
          step(1'b1, "stall_enter");
          run_wait(t, nx);
        end else begin
          if (t.wb_en) push(1'b0, t.dest, t.alu);
          step(1'b0, "stall_alu");
        end
      end
    endcase
    flush      = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin : driver
    txn_t gap, cur, nx;
    gap = mk(1, 1'b0, 1'b0, '0, '0, '0, 0, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU write
    run(mk(0, 1'b1, 1'b0, 4'd3, 32'h1234, '0, 0, 1, 1'b0), gap);
    // Load with latency 4
    run(mk(0, 1'b1, 1'b1, 4'd5, '0, 32'hCAFEF00D, 0, 4, 1'b0), gap);
    // Timeout, then a late rvalid that must be ignored
    run(mk(0, 1'b1, 1'b1, 4'd6, '0, '0, 1, int'(MAXW), 1'b0), gap);
    run(mk(3, 1'b0, 1'b0, '0, '0, '0, 0, 1, 1'b0), gap);
    // Flush colliding with rvalid
    run(mk(0, 1'b1, 1'b1, 4'd7, '0, 32'h5555AAAA, 2, 3, 1'b1), gap);
    // Data returning on the very last allowed cycle, dest 15 not filtered
    run(mk(0, 1'b1, 1'b1, 4'd15, '0, 32'h0BADBEEF, 0, int'(MAXW), 1'b0), gap);
    // Back-to-back with the third instruction held during the stall
    begin
      txn_t a, b, c;
      a = mk(0, 1'b1, 1'b0, 4'd1, 32'hA, '0, 0, 1, 1'b0);
      b = mk(0, 1'b1, 1'b1, 4'd2, '0, 32'hB0B0B0B0, 0, 2, 1'b0);
      c = mk(0, 1'b1, 1'b0, 4'd3, 32'hC, '0, 0, 1, 1'b0);
      run(a, b);
      run(b, c);
      run(c, gap);
    end
    // Reset in the middle of a wait; later rvalid ignored
    present(mk(0, 1'b1, 1'b1, 4'd9, '0, '0, 0, 1, 1'b0));
    step(1'b1, "stall_enter_rst");
    in_valid = 1'b0;
    step(1'b1, "stall_wait_rst");
    rst = 1'b1;
    step(1'b0, "stall_after_rst");
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADDEAD;
    step(1'b0, "stall_rvalid_after_rst");
    mem_rvalid = 1'b0;
    step(1'b0, "stall_idle_after_rst");

    // Randomised traffic
    cur = gen();
    for (int n = 0; n < 300; n++) begin
      nx = gen();
      run(cur, nx);
      cur = nx;
    end

    in_valid = 1'b0;
    repeat (3) step(1'b0, "stall_drain");
    chk("scoreboard_drained", 32'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_writeback_ctrl
